perf_counter_sampler: RTL and testbench
=======================================

# perf_counter_sampler

Autonomous reader for the performance-counter file: on a periodic timer tick or software request it sweeps a contiguous range of counter indices over the counter file's SRAM-like read port and streams one `{index, value}` record per counter through a valid/ready interface into a small FIFO. It sits beside the CSR file in the core, sharing the counter file's address/data read port through the CSR mux. Its output feeds trace/telemetry logic that cannot issue CSR reads itself.

## Interface
- `FIRST_IDX`, default `riscv::IDX_L1_ICACHE_MISS`: first counter index swept.
- `LAST_IDX`, default `riscv::IDX_IF_EMPTY`: last counter index swept; requires `LAST_IDX >= FIRST_IDX`.
- `FIFO_DEPTH`, default 4: record FIFO entries; power of two, at least 2.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset; synchronous, active-high`
- `enable_i  in  1  enables timer and triggers; a sweep already in progress completes regardless`
- `debug_mode_i  in  1  core in debug mode; new sweeps do not start`
- `period_i  in  32  timer period in cycles; 0 disables periodic triggering`
- `sw_trigger_i  in  1  single-cycle software sweep request`
- `perf_addr_o  out  5  counter index driven to the counter file`
- `perf_data_i  in  64  counter value; combinational from `perf_addr_o`, same cycle`
- `rec_valid_o  out  1  record valid`
- `rec_ready_i  in  1  consumer accepts record`
- `rec_idx_o  out  5  counter index of record`
- `rec_data_o  out  64  value (raw or delta, see Configuration)`
- `rec_last_o  out  1  record is `LAST_IDX` of its sweep`
- `rec_seq_o  out  16  sweep sequence number, wraps mod 2^16`
- `busy_o  out  1  sweep in progress`
- `overrun_o  out  16  dropped-trigger count, saturating`

## Operation
- Write-enable and write-data of the counter file are never driven by this block; the CSR mux ties them off while it owns the port.
- Trigger sources:
  - timer fire: `timer_q == period_i-1` with `period_i != 0`;
  - `sw_trigger_i`.
  - Both sources are gated by `enable_i`, and simultaneous events count as one trigger.
- Timer:
  - Free-running 32-bit counter, cleared on fire.
  - Cleared and held at 0 while `!enable_i` or `period_i == 0`.
- FSM `IDLE`:
  - Moves to `SWEEP` on a trigger or `pending_q`, when `!debug_mode_i`.
  - Entering `SWEEP` loads `idx_q = FIRST_IDX` and clears `pending_q`.
- FSM `SWEEP`:
  - Each cycle with the FIFO not full, reads `perf_data_i` at `perf_addr_o = idx_q` and pushes the record.
  - Then increments `idx_q`. After pushing `LAST_IDX`, increments `seq_q` and returns to `IDLE`.
  - If the FIFO is full, `idx_q` holds and nothing is pushed.
- Triggers that arrive while `busy_o`, or while a start is blocked by `debug_mode_i`:
  - If `pending_q` is clear, set it.
  - Otherwise increment `overrun_o`, saturating at 0xFFFF.
- `perf_addr_o = idx_q` in `SWEEP`, `FIRST_IDX` in `IDLE`.
- FIFO:
  - Records leave in push order; handshake completes when `rec_valid_o && rec_ready_i`.
  - `rec_*` are stable while `rec_valid_o && !rec_ready_i`.
  - Push and pop in the same cycle are allowed when full.

## Timing
- Reset clears every register:
  - all outputs 0 except `perf_addr_o = FIRST_IDX`;
  - state `IDLE`, `timer_q`, `pending_q`, `seq_q`, `overrun_o` and the delta snapshots 0.
- Trigger sampled at cycle t → `busy_o` high and first read at t+1 → first `rec_valid_o` at t+2.
- Registered FIFO output: push at cycle c is visible at c+1 at the earliest.
- Unstalled sweep: N = `LAST_IDX-FIRST_IDX+1` cycles; `busy_o` falls the cycle after the last push.
- Back-to-back: if `pending_q` is set at sweep end, the next sweep starts immediately; there is one `IDLE` cycle between sweeps.
- Reset mid-sweep: the sweep is abandoned, the FIFO is emptied and no partial record survives.

## Configuration
- `PERF_SAMPLER_DELTA_EN` defined:
  - Keeps an N×64 snapshot array.
  - `rec_data_o = perf_data_i - snapshot[idx]` mod 2^64, and the snapshot is updated on push.
  - The first sweep after reset reports raw values.
- Undefined: no snapshot array; `rec_data_o` is the raw counter value.

## Structure
- `ariane_pkg`:
  - `perf_sample_t` (`idx[4:0]`, `data[63:0]`, `last`, `seq[15:0]`);
  - `perf_sampler_state_e` (`IDLE`, `SWEEP`).
- Sub-module: `perf_sample_fifo`, a parameterised synchronous FIFO of `perf_sample_t` with full/empty.

## Test plan
- `period_i = 100`, `enable_i = 1`, counters preset to index×10, consumer always ready → a sweep every 100 cycles.
  - Records carry `idx = FIRST_IDX..LAST_IDX` with `data = idx×10`, `rec_last_o` only on `LAST_IDX`, and `rec_seq_o` = 0, 1, 2.
- `sw_trigger_i` pulse at cycle 10 → `rec_valid_o` at cycle 12 and `busy_o` during 11..10+N.
- `rec_ready_i = 0` during a sweep → exactly `FIFO_DEPTH` pushes, then `perf_addr_o` holds.
  - Releasing ready resumes the sweep with no lost or duplicated indices.
- Three `sw_trigger_i` pulses during one sweep → one extra sweep follows and `overrun_o = 2`.
- `debug_mode_i = 1` at a trigger → no sweep; the sweep starts the cycle after `debug_mode_i` falls.
- With `PERF_SAMPLER_DELTA_EN`, a counter goes 5 → 12 → 12 across sweeps → records 5, 7, 0.
  - Counter 2^64-1 → 3 gives a delta of 4.

Source files
------------

// File: rtl/perf_counter_sampler_pkg.sv
// rtl/perf_counter_sampler_pkg.sv - shared record type, FSM states and counter indices for the sampler
package perf_counter_sampler_pkg;

  // Counter-file indices of the default sweep window
  localparam logic [4:0] IDX_L1_ICACHE_MISS = 5'd3;
  localparam logic [4:0] IDX_IF_EMPTY       = 5'd16;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
    logic [15:0] seq;
  } perf_sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } perf_sampler_state_e;

endpackage

// File: rtl/perf_sample_fifo.sv
// rtl/perf_sample_fifo.sv - synchronous record FIFO with registered storage and full/empty flags
module perf_sample_fifo
  import perf_counter_sampler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  perf_sample_t data_i,
  input  logic         pop_i,
  output perf_sample_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  perf_sample_t mem_q [DEPTH];
  perf_sample_t mem_d [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  // Occupancy from pointers (extra MSB separates full from empty); a pop frees room for a same-cycle push
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = data_i;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    data_o = mem_q[rptr_q[AW-1:0]];
  end

  // Storage and pointers; reset empties the FIFO and zeroes every entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/perf_counter_sampler.sv
// rtl/perf_counter_sampler.sv - timer/sw triggered perf counter sweeper; PERF_SAMPLER_DELTA_EN selects delta records
module perf_counter_sampler
  import perf_counter_sampler_pkg::*;
#(
  parameter logic [4:0] FIRST_IDX  = IDX_L1_ICACHE_MISS,
  parameter logic [4:0] LAST_IDX   = IDX_IF_EMPTY,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        debug_mode_i,
  input  logic [31:0] period_i,
  input  logic        sw_trigger_i,
  output logic [4:0]  perf_addr_o,
  input  logic [63:0] perf_data_i,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic [4:0]  rec_idx_o,
  output logic [63:0] rec_data_o,
  output logic        rec_last_o,
  output logic [15:0] rec_seq_o,
  output logic        busy_o,
  output logic [15:0] overrun_o
);

  localparam int N = int'(LAST_IDX) - int'(FIRST_IDX) + 1;

  perf_sampler_state_e state_q, state_d;
  logic [31:0]         timer_q, timer_d;
  logic [4:0]          idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [15:0]         seq_q, seq_d;
  logic [15:0]         overrun_q, overrun_d;

  logic         timer_fire, trigger, start, can_push, push, sweep_done;
  logic         fifo_full, fifo_empty;
  perf_sample_t rec_in, rec_out;

`ifdef PERF_SAMPLER_DELTA_EN
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  logic [63:0]   snap_q [N];
  logic [63:0]   snap_d [N];
  logic [SW-1:0] slot;
`endif

  // Trigger qualification and push handshake; a full FIFO still accepts when the consumer pops this cycle
  always_comb begin
    timer_fire = enable_i && (period_i != 32'd0) && (timer_q == period_i - 32'd1);
    trigger    = enable_i && (timer_fire || sw_trigger_i);
    start      = (state_q == IDLE) && (trigger || pending_q) && !debug_mode_i;
    can_push   = !fifo_full || rec_ready_i;
    push       = (state_q == SWEEP) && can_push;
    sweep_done = push && (idx_q == LAST_IDX);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (sweep_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: timer, sweep index, trigger bookkeeping, record assembly
  always_comb begin
    timer_d = (!enable_i || (period_i == 32'd0) || timer_fire) ? 32'd0 : timer_q + 32'd1;

    idx_d = idx_q;
    if (start) begin
      idx_d = FIRST_IDX;
    end else if (push && !sweep_done) begin
      idx_d = idx_q + 5'd1;
    end

    seq_d = sweep_done ? seq_q + 16'd1 : seq_q;

    // A trigger that cannot start a sweep is remembered once; further ones are counted as dropped
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (start) begin
      pending_d = 1'b0;
    end else if (trigger) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overrun_q != 16'hFFFF) begin
        overrun_d = overrun_q + 16'd1;
      end
    end

    perf_addr_o = (state_q == SWEEP) ? idx_q : FIRST_IDX;
    busy_o      = (state_q == SWEEP);

    rec_in.idx  = idx_q;
    rec_in.last = (idx_q == LAST_IDX);
    rec_in.seq  = seq_q;
`ifdef PERF_SAMPLER_DELTA_EN
    // Snapshots start at zero, so the first sweep after reset reports raw values
    slot        = SW'(idx_q - FIRST_IDX);
    rec_in.data = perf_data_i - snap_q[slot];
    snap_d      = snap_q;
    if (push) begin
      snap_d[slot] = perf_data_i;
    end
`else
    rec_in.data = perf_data_i;
`endif
  end

  // State register and all control flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      seq_q     <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PERF_SAMPLER_DELTA_EN
  // Per-counter snapshot of the last value pushed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= '{default: '0};
    end else begin
      snap_q <= snap_d;
    end
  end
`endif

  perf_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (rec_ready_i),
    .data_o  (rec_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid_o = !fifo_empty;
  assign rec_idx_o   = rec_out.idx;
  assign rec_data_o  = rec_out.data;
  assign rec_last_o  = rec_out.last;
  assign rec_seq_o   = rec_out.seq;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// tb/tb_perf_counter_sampler.sv - directed self-checking bench for perf_counter_sampler
module tb_perf_counter_sampler;
  import perf_counter_sampler_pkg::*;

  localparam logic [4:0] FI = IDX_L1_ICACHE_MISS;
  localparam logic [4:0] LI = IDX_IF_EMPTY;
  localparam int         N  = int'(LI) - int'(FI) + 1;

  logic        clk = 1'b0;
  logic        rst, enable, debug_mode, sw_trigger, rec_ready;
  logic [31:0] period;
  logic [4:0]  perf_addr;
  logic [63:0] perf_data;
  logic        rec_valid, rec_last, busy;
  logic [4:0]  rec_idx;
  logic [63:0] rec_data;
  logic [15:0] rec_seq, overrun;

  logic [63:0]  ctr_mem [32];
  logic [63:0]  snap_m  [32];
  perf_sample_t rec_q [$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  assign perf_data = ctr_mem[perf_addr];

  perf_counter_sampler dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .debug_mode_i (debug_mode),
    .period_i     (period),
    .sw_trigger_i (sw_trigger),
    .perf_addr_o  (perf_addr),
    .perf_data_i  (perf_data),
    .rec_valid_o  (rec_valid),
    .rec_ready_i  (rec_ready),
    .rec_idx_o    (rec_idx),
    .rec_data_o   (rec_data),
    .rec_last_o   (rec_last),
    .rec_seq_o    (rec_seq),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  // Log every completed handshake; inputs only change just after posedge
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      rec_q.push_back('{idx: rec_idx, data: rec_data, last: rec_last, seq: rec_seq});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sw();
    sw_trigger = 1'b1;
    step();
    sw_trigger = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (!busy && !rec_valid) return;
      step();
    end
    chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // Pop one sweep of records and compare against the counter file (and the delta model if enabled)
  task automatic check_sweep(input logic [15:0] seq);
    perf_sample_t r;
    logic [4:0]   ei;
    logic [63:0]  e;
    chk("sweep_len", 64'(rec_q.size() >= N), 64'd1);
    for (int k = 0; k < N && rec_q.size() > 0; k++) begin
      r  = rec_q.pop_front();
      ei = FI + 5'(k);
      e  = ctr_mem[ei];
`ifdef PERF_SAMPLER_DELTA_EN
      e          = ctr_mem[ei] - snap_m[ei];
      snap_m[ei] = ctr_mem[ei];
`endif
      chk("rec_idx", r.idx, ei);
      chk("rec_data", r.data, e);
      chk("rec_last", r.last, (k == N - 1));
      chk("rec_seq", r.seq, seq);
    end
  endtask

  initial begin
    int   rises [$];
    logic prev;
    logic bz [40];
    int   nbusy;

    for (int i = 0; i < 32; i++) begin
      ctr_mem[i] = 64'(i * 10);
      snap_m[i]  = '0;
    end
    rst = 1'b1; enable = 1'b0; debug_mode = 1'b0; sw_trigger = 1'b0;
    rec_ready = 1'b1; period = 32'd0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_addr", perf_addr, FI);
    chk("rst_overrun", overrun, 16'd0);
    chk("rst_seq", rec_seq, 16'd0);
    chk("rst_data", rec_data, 64'd0);
    chk("rst_idx", rec_idx, 5'd0);

    // Periodic sweeps every 100 cycles
    enable = 1'b1;
    period = 32'd100;
    prev   = 1'b0;
    for (int i = 1; i <= 350; i++) begin
      step();
      if (busy && !prev) rises.push_back(i);
      prev = busy;
    end
    period = 32'd0;
    chk("period_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("period_rise0", rises[0], 100);
      chk("period_rise1", rises[1], 200);
      chk("period_rise2", rises[2], 300);
    end
    drain();
    check_sweep(16'd0);
    check_sweep(16'd1);
    check_sweep(16'd2);

    // Software trigger latency and busy width
    pulse_sw();
    chk("sw_busy_t1", busy, 1'b1);
    chk("sw_valid_t1", rec_valid, 1'b0);
    chk("sw_addr_t1", perf_addr, FI);
    step();
    chk("sw_valid_t2", rec_valid, 1'b1);
    chk("sw_idx_t2", rec_idx, FI);
    chk("sw_data_t2", rec_data, 64'(int'(FI) * 10));
    chk("sw_addr_t2", perf_addr, FI + 5'd1);
    nbusy = 2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) nbusy++;
    end
    chk("sw_busy_cycles", nbusy, N);
    drain();
    check_sweep(16'd3);

    // Back-pressure: FIFO fills, address holds, then resumes cleanly
    rec_ready = 1'b0;
    pulse_sw();
    repeat (10) step();
    chk("bp_addr_hold", perf_addr, FI + 5'd4);
    chk("bp_busy", busy, 1'b1);
    chk("bp_valid", rec_valid, 1'b1);
    chk("bp_head_idx", rec_idx, FI);
    chk("bp_no_pops", rec_q.size(), 0);
    rec_ready = 1'b1;
    drain();
    check_sweep(16'd4);

    // Three extra triggers during one sweep: one queued sweep, two overruns
    pulse_sw();
    for (int i = 0; i < 40; i++) begin
      bz[i]      = busy;
      sw_trigger = (i == 2 || i == 4 || i == 6);
      step();
    end
    sw_trigger = 1'b0;
    chk("b2b_busy13", bz[13], 1'b1);
    chk("b2b_idle14", bz[14], 1'b0);
    chk("b2b_busy15", bz[15], 1'b1);
    chk("b2b_busy28", bz[28], 1'b1);
    chk("b2b_idle29", bz[29], 1'b0);
    chk("b2b_overrun", overrun, 16'd2);
    drain();
    check_sweep(16'd5);
    check_sweep(16'd6);
    chk("b2b_no_extra", rec_q.size(), 0);

    // Debug mode holds off the start until it falls
    debug_mode = 1'b1;
    pulse_sw();
    repeat (5) step();
    chk("dbg_no_sweep", busy, 1'b0);
    chk("dbg_overrun", overrun, 16'd2);
    debug_mode = 1'b0;
    step();
    chk("dbg_start", busy, 1'b1);
    drain();
    check_sweep(16'd7);
    repeat (20) step();
    chk("dbg_single", rec_q.size(), 0);
    chk("dbg_idle", busy, 1'b0);

    // Enable gates the software trigger
    enable = 1'b0;
    pulse_sw();
    step();
    chk("en_gated", busy, 1'b0);
    enable = 1'b1;

`ifdef PERF_SAMPLER_DELTA_EN
    // Delta records: 5 -> 12 -> 12 gives 5, 7, 0; all-ones -> 3 wraps to 4
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) snap_m[i] = '0;
    ctr_mem[FI]        = 64'd5;
    ctr_mem[FI + 5'd1] = 64'hFFFF_FFFF_FFFF_FFFF;
    pulse_sw();
    drain();
    chk("delta_len0", 64'(rec_q.size() >= 2), 64'd1);
    chk("delta_first", rec_q[0].data, 64'd5);
    check_sweep(16'd0);
    ctr_mem[FI]        = 64'd12;
    ctr_mem[FI + 5'd1] = 64'd3;
    pulse_sw();
    drain();
    chk("delta_len1", 64'(rec_q.size() >= 2), 64'd1);
    chk("delta_second", rec_q[0].data, 64'd7);
    chk("delta_wrap", rec_q[1].data, 64'd4);
    check_sweep(16'd1);
    pulse_sw();
    drain();
    chk("delta_len2", 64'(rec_q.size() >= 1), 64'd1);
    chk("delta_third", rec_q[0].data, 64'd0);
    check_sweep(16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
